// File: rtl/tick_debouncer_if.sv
// Pin-level bundle between the debouncer and its surroundings: tick/din in, clean level and strobes out.
// The master side drives tick and din; the slave side (the debouncer) drives dout, rise and fall.
interface tick_debouncer_if;
   logic tick;
   logic din;
   logic dout;
   logic rise;
   logic fall;

   modport master (
      output tick,
      output din,
      input  dout,
      input  rise,
      input  fall
   );

   modport slave (
      input  tick,
      input  din,
      output dout,
      output rise,
      output fall
   );
endinterface

// File: rtl/tick_debouncer.sv
// Debounces one asynchronous pin using the prescaler tick as a sample enable;
// produces a registered clean level plus single-cycle rise/fall strobes.
module tick_debouncer #(
   parameter int   STABLE_TICKS = 3,
   parameter int   CNT_WIDTH    = 2,
   parameter logic INIT_LEVEL   = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   tick_debouncer_if.slave    bus
);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_CONFIRM = 1'b1
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_TICKS - 1);

   logic                 r_sync1;
   logic                 r_sync2;
   state_t               r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_dout;
   logic                 r_rise;
   logic                 r_fall;
   logic                 w_diff;

   assign w_diff = (r_sync2 != r_dout);

   // NOTE: every flop here takes its reset value asynchronously so the outputs are clean
   // the instant rst_n falls, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= INIT_LEVEL;
         r_sync2 <= INIT_LEVEL;
      end else begin
         // NOTE: non-blocking assignments make sync2 take the old sync1, forming a true 2-flop chain.
         r_sync1 <= bus.din;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_STABLE;
         r_cnt   <= '0;
         r_dout  <= INIT_LEVEL;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         // Strobes last one clock regardless of tick; only state, cnt and dout wait for tick.
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (bus.tick) begin
            unique case (r_state)
               ST_STABLE: begin
                  if (!w_diff) begin
                     r_cnt <= '0;
                  end else if (STABLE_TICKS == 1) begin
                     r_dout <= ~r_dout;
                     r_rise <= ~r_dout;
                     r_fall <= r_dout;
                  end else begin
                     r_state <= ST_CONFIRM;
                     r_cnt   <= CNT_ONE;
                  end
               end
               ST_CONFIRM: begin
                  if (!w_diff) begin
                     r_state <= ST_STABLE;
                     r_cnt   <= '0;
                  end else if (r_cnt == CNT_LAST) begin
                     r_dout  <= ~r_dout;
                     r_rise  <= ~r_dout;
                     r_fall  <= r_dout;
                     r_state <= ST_STABLE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_ONE;
                  end
               end
               default: begin
                  r_state <= ST_STABLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.dout = r_dout;
   assign bus.rise = r_rise;
   assign bus.fall = r_fall;

endmodule

// File: tb/tb_tick_debouncer.sv
// Scoreboard bench: a 3-tick debouncer on a 4-clock tick and a 1-tick debouncer with tick tied high,
// both fed the same din/rst_n and checked every cycle against a run-length reference model.
module tb_tick_debouncer;

   localparam int N0 = 3;
   localparam int N1 = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   tick_debouncer_if bus0 ();
   tick_debouncer_if bus1 ();

   tick_debouncer #(.STABLE_TICKS(N0), .CNT_WIDTH(2), .INIT_LEVEL(1'b0)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   tick_debouncer #(.STABLE_TICKS(N1), .CNT_WIDTH(1), .INIT_LEVEL(1'b0)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic dout;
      logic rise;
      logic fall;
   } exp_t;

   exp_t exp_q0[$];
   exp_t exp_q1[$];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: din seen by the debouncer two edges late, and a run of consecutive differing samples.
   logic m_hist[$];
   logic m_lvl[2];
   int   m_run[2];
   int   phase    = 0;
   bit   tick_rnd = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_edge(input logic rst, input logic t0, input logic t1, input logic d);
      exp_t e;
      logic s;
      logic t;
      int   n;
      if (!rst) begin
         m_hist = '{1'b0, 1'b0};
         for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 1'b0;
            m_run[i] = 0;
         end
         e = '0;
         exp_q0.push_back(e);
         exp_q1.push_back(e);
      end else begin
         s = m_hist[0];
         void'(m_hist.pop_front());
         m_hist.push_back(d);
         for (int i = 0; i < 2; i++) begin
            t = (i == 0) ? t0 : t1;
            n = (i == 0) ? N0 : N1;
            e = '0;
            if (t) begin
               if (s != m_lvl[i]) begin
                  m_run[i]++;
                  if (m_run[i] == n) begin
                     m_lvl[i] = ~m_lvl[i];
                     e.rise   = m_lvl[i];
                     e.fall   = ~m_lvl[i];
                     m_run[i] = 0;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
            e.dout = m_lvl[i];
            if (i == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
         end
      end
   endtask

   task automatic step(input logic rst, input logic d);
      logic t0;
      @(negedge clk);
      t0 = tick_rnd ? ($urandom_range(0, 2) == 0) : (phase % 4 == 3);
      phase++;
      rst_n     = rst;
      bus0.din  = d;
      bus1.din  = d;
      bus0.tick = t0;
      bus1.tick = 1'b1;
      model_edge(rst, t0, 1'b1, d);
   endtask

   task automatic hold(input logic d, input int n);
      for (int i = 0; i < n; i++) step(1'b1, d);
   endtask

   task automatic reset_now(input logic d);
      step(1'b0, d);
      #1;
      check("rst_async_dout3", bus0.dout, 0);
      check("rst_async_dout1", bus1.dout, 0);
      check("rst_async_strb3", {bus0.rise, bus0.fall}, 0);
   endtask

   // Monitor: one expected triple per clock, compared just after the active edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check("dut3_dout", bus0.dout, e.dout);
            check("dut3_rise", bus0.rise, e.rise);
            check("dut3_fall", bus0.fall, e.fall);
            check("dut3_excl", bus0.rise & bus0.fall, 0);
         end
         if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check("dut1_dout", bus1.dout, e.dout);
            check("dut1_rise", bus1.rise, e.rise);
            check("dut1_fall", bus1.fall, e.fall);
         end
      end
   end

   initial begin
      bus0.din  = 1'b0;
      bus1.din  = 1'b0;
      bus0.tick = 1'b0;
      bus1.tick = 1'b1;
      m_hist    = '{1'b0, 1'b0};
      m_lvl     = '{1'b0, 1'b0};
      m_run     = '{0, 0};

      // Reset held with din toggling and tick pulsing, then release with din low.
      for (int i = 0; i < 8; i++) step(1'b0, logic'($urandom_range(0, 1)));
      hold(1'b0, 10);

      // Glitch: two tick samples high, then low before the third; then a clean rise.
      hold(1'b1, 8);
      hold(1'b0, 8);
      hold(1'b1, 20);

      // Bounce down: toggle every clock, then settle low.
      for (int i = 0; i < 10; i++) step(1'b1, logic'(i % 2));
      hold(1'b0, 24);

      // Mid-confirm resets, once from dout=1 and once from dout=0.
      hold(1'b1, 20);
      hold(1'b0, 10);
      reset_now(1'b0);
      hold(1'b0, 12);
      hold(1'b1, 10);
      reset_now(1'b1);
      hold(1'b1, 24);

      // Randomized bursts with irregular tick and occasional resets.
      tick_rnd = 1'b1;
      for (int b = 0; b < 60; b++) begin
         if ($urandom_range(0, 29) == 0) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(1'b0, logic'($urandom_range(0, 1)));
         end
         hold(logic'($urandom_range(0, 1)), int'($urandom_range(1, 15)));
      end
      tick_rnd = 1'b0;
      hold(1'b0, 20);

      repeat (3) @(posedge clk);
      #2;
      check("sb_drain3", exp_q0.size(), 0);
      check("sb_drain1", exp_q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
